// File: rtl/power_management_controller.sv
// power_management_controller
//   Per-domain clock power-down / wake-up sequencer for the RT-Core (bit 0),
//   GP-Core (bit 1) and peripheral (bit 2) domains. Each domain runs an
//   independent ACTIVE -> REQ -> GATED -> WAKE FSM in the always-on clock.
// Ports:
//   clk_periph_25mhz, rst_n_periph : clock, synchronous active-low reset
//   clocks_stable                  : low holds every domain in ACTIVE
//   sleep_cmd, wake_cmd            : single-cycle software requests [2:0]
//   wake_event, auto_en, idle      : per-domain levels [2:0]
//   sleep_ack                      : domain quiesce acknowledge [2:0]
//   status_clear                   : clears sticky timeout flags
//   sleep_req, domain_ready        : per-domain handshake / ready [2:0]
//   power_down_rt/gp/periph        : to the clock management unit
//   timeout_flag                   : sticky ack-timeout flags [2:0]
//   pm_state                       : 2-bit state per domain, [2d+1:2d]

module pmc_domain #(
  parameter int ACK_TIMEOUT = 255,
  parameter int WAKE_CYCLES = 16,
  parameter int IDLE_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clocks_stable_i,
  input  logic       sleep_cmd_i,
  input  logic       wake_cmd_i,
  input  logic       wake_event_i,
  input  logic       auto_en_i,
  input  logic       idle_i,
  input  logic       sleep_ack_i,
  input  logic       status_clear_i,
  output logic       sleep_req_o,
  output logic       power_down_o,
  output logic       domain_ready_o,
  output logic       timeout_flag_o,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {ACTIVE = 2'b00, REQ = 2'b01, GATED = 2'b10, WAKE = 2'b11} state_e;

  localparam int CNT_MAX = (ACK_TIMEOUT > WAKE_CYCLES) ? ACK_TIMEOUT : WAKE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(IDLE_CYCLES);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          flag_q, flag_d, set_flag;
  logic          sleep_req_q, power_down_q, ready_q;
  logic          wake, auto_idle;

  assign wake      = wake_cmd_i | wake_event_i;
  assign auto_idle = auto_en_i & idle_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = '0;
    set_flag = 1'b0;
    unique case (state_q)
      ACTIVE: begin
        cnt_d = '0;
        // A pending event vetoes both software and idle-triggered sleep.
        if (auto_idle && !wake_event_i)
          idle_d = (idle_q == '1) ? idle_q : idle_q + IW'(1);
        if (!wake_event_i && (sleep_cmd_i || (auto_idle && idle_q == IDLE_LAST))) begin
          state_d = REQ;
          idle_d  = '0;
        end
      end
      REQ: begin
        if (wake) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (sleep_ack_i) begin
          state_d = GATED;
          cnt_d   = '0;
        end else if (cnt_q == ACK_LAST) begin
          state_d  = ACTIVE;
          cnt_d    = '0;
          set_flag = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GATED: begin
        cnt_d = '0;
        if (wake) state_d = WAKE;
      end
      WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
    // Unstable clocks: park in ACTIVE, but keep sticky flags.
    if (!clocks_stable_i) begin
      state_d  = ACTIVE;
      cnt_d    = '0;
      idle_d   = '0;
      set_flag = 1'b0;
    end
    flag_d = set_flag ? 1'b1 : (status_clear_i ? 1'b0 : flag_q);
  end

  // Outputs decode the next state so they move together with pm_state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ACTIVE;
      cnt_q        <= '0;
      idle_q       <= '0;
      flag_q       <= 1'b0;
      sleep_req_q  <= 1'b0;
      power_down_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      flag_q       <= flag_d;
      sleep_req_q  <= (state_d == REQ);
      power_down_q <= (state_d == GATED);
      ready_q      <= (state_d == ACTIVE) && clocks_stable_i;
    end
  end

  assign sleep_req_o    = sleep_req_q;
  assign power_down_o   = power_down_q;
  assign domain_ready_o = ready_q;
  assign timeout_flag_o = flag_q;
  assign state_o        = state_q;
endmodule

module power_management_controller #(
  parameter int ACK_TIMEOUT = 255,
  parameter int WAKE_CYCLES = 16,
  parameter int IDLE_CYCLES = 1024
) (
  input  logic       clk_periph_25mhz,
  input  logic       rst_n_periph,
  input  logic       clocks_stable,
  input  logic [2:0] sleep_cmd,
  input  logic [2:0] wake_cmd,
  input  logic [2:0] wake_event,
  input  logic [2:0] auto_en,
  input  logic [2:0] idle,
  input  logic [2:0] sleep_ack,
  input  logic       status_clear,
  output logic [2:0] sleep_req,
  output logic       power_down_rt,
  output logic       power_down_gp,
  output logic       power_down_periph,
  output logic [2:0] domain_ready,
  output logic [2:0] timeout_flag,
  output logic [5:0] pm_state
);
  localparam int NUM_DOM = 3;

  logic [NUM_DOM-1:0] pd;

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    pmc_domain #(
      .ACK_TIMEOUT(ACK_TIMEOUT),
      .WAKE_CYCLES(WAKE_CYCLES),
      .IDLE_CYCLES(IDLE_CYCLES)
    ) u_dom (
      .clk_i          (clk_periph_25mhz),
      .rst_ni         (rst_n_periph),
      .clocks_stable_i(clocks_stable),
      .sleep_cmd_i    (sleep_cmd[g]),
      .wake_cmd_i     (wake_cmd[g]),
      .wake_event_i   (wake_event[g]),
      .auto_en_i      (auto_en[g]),
      .idle_i         (idle[g]),
      .sleep_ack_i    (sleep_ack[g]),
      .status_clear_i (status_clear),
      .sleep_req_o    (sleep_req[g]),
      .power_down_o   (pd[g]),
      .domain_ready_o (domain_ready[g]),
      .timeout_flag_o (timeout_flag[g]),
      .state_o        (pm_state[2*g +: 2])
    );
  end

  assign power_down_rt     = pd[0];
  assign power_down_gp     = pd[1];
  assign power_down_periph = pd[2];
endmodule

// File: tb/tb_power_management_controller.sv
// Directed bench for power_management_controller with ACK_TIMEOUT=8,
// WAKE_CYCLES=4, IDLE_CYCLES=16. Inputs are driven and outputs sampled
// 1 ns after each rising edge.

module tb_power_management_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       stable;
  logic [2:0] sleep_cmd, wake_cmd, wake_event, auto_en, idle, sleep_ack;
  logic       status_clear;
  logic [2:0] sleep_req, domain_ready, timeout_flag;
  logic       pd_rt, pd_gp, pd_pe;
  logic [5:0] pm_state;

  int vectors     = 0;
  int miscompares = 0;

  power_management_controller #(
    .ACK_TIMEOUT(8),
    .WAKE_CYCLES(4),
    .IDLE_CYCLES(16)
  ) dut (
    .clk_periph_25mhz (clk),
    .rst_n_periph     (rst_n),
    .clocks_stable    (stable),
    .sleep_cmd        (sleep_cmd),
    .wake_cmd         (wake_cmd),
    .wake_event       (wake_event),
    .auto_en          (auto_en),
    .idle             (idle),
    .sleep_ack        (sleep_ack),
    .status_clear     (status_clear),
    .sleep_req        (sleep_req),
    .power_down_rt    (pd_rt),
    .power_down_gp    (pd_gp),
    .power_down_periph(pd_pe),
    .domain_ready     (domain_ready),
    .timeout_flag     (timeout_flag),
    .pm_state         (pm_state)
  );

  always #20 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole output bundle in one vector: {pd_pe,pd_gp,pd_rt,sleep_req,ready}
  function automatic logic [7:0] ctl();
    return {2'b00, pd_pe, pd_gp, pd_rt, sleep_req[0] | sleep_req[1] | sleep_req[2], 2'b00} | 8'(domain_ready);
  endfunction

  initial begin
    rst_n = 1'b0; stable = 1'b0; status_clear = 1'b0;
    sleep_cmd = '0; wake_cmd = '0; wake_event = '0;
    auto_en = '0; idle = '0; sleep_ack = '0;

    // 1. reset and stable gating
    tick(2);
    chk("rst_state", 8'(pm_state), 8'h00);
    chk("rst_outs", {1'b0, timeout_flag, sleep_req, pd_rt}, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("unstable_ready", 8'(domain_ready), 8'h00);
    chk("unstable_pd", {5'b0, pd_pe, pd_gp, pd_rt}, 8'h00);
    stable = 1'b1;
    tick();
    chk("stable_ready", 8'(domain_ready), 8'h07);

    // 2. full RT cycle
    sleep_cmd = 3'b001;
    tick();
    sleep_cmd = '0;
    chk("rt_req", 8'(sleep_req), 8'h01);
    chk("rt_req_state", 8'(pm_state), 8'h01);
    tick(2);
    sleep_ack = 3'b001;
    tick();
    sleep_ack = '0;
    chk("rt_gated_pd", {6'b0, sleep_req[0], pd_rt}, 8'h01);
    chk("rt_gated_state", 8'(pm_state[1:0]), 8'h02);
    chk("rt_gated_ready", 8'(domain_ready), 8'h06);
    sleep_cmd = 3'b001;
    tick();
    sleep_cmd = '0;
    chk("rt_gated_ignore_sleep", 8'(pm_state[1:0]), 8'h02);
    wake_event = 3'b001;
    tick();
    wake_event = '0;
    chk("rt_wake_pd", 8'(pd_rt), 8'h00);
    chk("rt_wake_state", 8'(pm_state[1:0]), 8'h03);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rt_settle_notready", 8'(domain_ready[0]), 8'h00);
    end
    tick();
    chk("rt_ready", 8'(domain_ready), 8'h07);
    chk("rt_active_state", 8'(pm_state), 8'h00);

    // wake and ack together in REQ: wake wins, no flag
    sleep_cmd = 3'b001;
    tick();
    sleep_cmd = '0;
    wake_cmd = 3'b001; sleep_ack = 3'b001;
    tick();
    wake_cmd = '0; sleep_ack = '0;
    chk("abort_state", 8'(pm_state), 8'h00);
    chk("abort_flag_pd", {4'b0, timeout_flag, pd_rt}, 8'h00);

    // 3. GP ack timeout
    sleep_cmd = 3'b010;
    tick();
    sleep_cmd = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("gp_wait_req", {5'b0, pd_gp, pm_state[3:2]}, 8'h01);
    end
    tick();
    chk("gp_timeout_state", 8'(pm_state), 8'h00);
    chk("gp_timeout_flag", 8'(timeout_flag), 8'h02);
    chk("gp_timeout_ready", 8'(domain_ready), 8'h07);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    chk("flag_clear", 8'(timeout_flag), 8'h00);
    // set wins over a simultaneous clear
    status_clear = 1'b1;
    sleep_cmd = 3'b010;
    tick();
    sleep_cmd = '0;
    tick(8);
    chk("flag_set_beats_clear", 8'(timeout_flag), 8'h02);
    tick();
    status_clear = 1'b0;
    chk("flag_clear_after", 8'(timeout_flag), 8'h00);

    // 4. ack on the last REQ cycle
    sleep_cmd = 3'b010;
    tick();
    sleep_cmd = '0;
    tick(7);
    chk("gp_last_req", 8'(pm_state[3:2]), 8'h01);
    sleep_ack = 3'b010;
    tick();
    sleep_ack = '0;
    chk("gp_last_ack_gated", {5'b0, pd_gp, pm_state[3:2]}, 8'h06);
    chk("gp_last_ack_noflag", 8'(timeout_flag), 8'h00);
    wake_cmd = 3'b010;
    tick();
    wake_cmd = '0;
    tick(4);
    chk("gp_back_ready", 8'(domain_ready), 8'h07);

    // 5. auto idle on PERIPH
    auto_en = 3'b100; idle = 3'b100;
    tick(15);
    chk("auto_not_yet", 8'(pm_state[5:4]), 8'h00);
    tick();
    chk("auto_req", 8'(pm_state[5:4]), 8'h01);
    chk("auto_req_out", 8'(sleep_req), 8'h04);
    idle = '0; wake_cmd = 3'b100;
    tick();
    wake_cmd = '0;
    chk("auto_abort", 8'(pm_state), 8'h00);

    idle = 3'b100;
    tick(10);
    idle = '0;
    tick();
    idle = 3'b100;
    tick(15);
    chk("drop_not_yet", 8'(pm_state[5:4]), 8'h00);
    tick();
    chk("drop_req", 8'(pm_state[5:4]), 8'h01);
    idle = '0; wake_cmd = 3'b100;
    tick();
    wake_cmd = '0;

    wake_event = 3'b100; idle = 3'b100;
    tick(5);
    sleep_cmd = 3'b100;
    tick();
    sleep_cmd = '0;
    tick(15);
    chk("veto_no_req", {2'b0, pm_state}, 8'h00);
    wake_event = '0;
    tick();
    chk("veto_counter_cleared", 8'(pm_state[5:4]), 8'h00);
    idle = '0; auto_en = '0;
    tick();

    // 6. reset during WAKE
    sleep_cmd = 3'b001;
    tick();
    sleep_cmd = '0; sleep_ack = 3'b001;
    tick();
    sleep_ack = '0; wake_event = 3'b001;
    tick();
    wake_event = '0;
    tick();
    chk("pre_rst_wake", 8'(pm_state[1:0]), 8'h03);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_state", 8'(pm_state), 8'h00);
    chk("mid_rst_outs", ctl(), 8'h00);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 8'(domain_ready), 8'h07);

    // stability loss while GATED, with an RT flag pending
    sleep_cmd = 3'b001;
    tick();
    sleep_cmd = '0;
    tick(8);
    chk("rt_flag_set", 8'(timeout_flag), 8'h01);
    sleep_cmd = 3'b010;
    tick();
    sleep_cmd = '0; sleep_ack = 3'b010;
    tick();
    sleep_ack = '0;
    chk("gp_gated_again", {5'b0, pd_gp, pm_state[3:2]}, 8'h06);
    stable = 1'b0;
    tick();
    chk("unstable_state", 8'(pm_state), 8'h00);
    chk("unstable_outs", ctl(), 8'h00);
    chk("unstable_flag_kept", 8'(timeout_flag), 8'h01);
    stable = 1'b1;
    tick();
    chk("restable_ready", 8'(domain_ready), 8'h07);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
